// File: rtl/exec_ctrl_unit.sv
// Execute/control slice: main opcode decoder, ALU-op decoder, 32-bit ALU and
// a small capture register holding the last enabled result and flag.
module exec_ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        jump_r,
  output logic        memtoreg,
  output logic        auipc,
  output logic [1:0]  alu_op,
  output logic        csr_read_en,
  output logic        csr_write_en,
  output logic        is_csr,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] result_q,
  output logic        zero_q
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;
  localparam logic [3:0] AluEq   = 4'b1010;
  localparam logic [3:0] AluNe   = 4'b1011;
  localparam logic [3:0] AluLt   = 4'b1100;
  localparam logic [3:0] AluGe   = 4'b1101;
  localparam logic [3:0] AluLtu  = 4'b1110;
  localparam logic [3:0] AluGeu  = 4'b1111;

  logic [31:0] op_a;
  logic [31:0] op_b;

  // Only funct7[5] distinguishes SUB/SRA; remaining bits are don't-care here.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Main decoder: opcode to datapath and CSR controls.
  always_comb begin
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    jump_r       = 1'b0;
    memtoreg     = 1'b0;
    auipc        = 1'b0;
    alu_op       = 2'b00;
    csr_read_en  = 1'b0;
    csr_write_en = 1'b0;
    is_csr       = 1'b0;
    case (opcode)
      OpR: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OpI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
      end
      OpLoad: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        mem_read  = 1'b1;
        memtoreg  = 1'b1;
      end
      OpStore: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OpBranch: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OpJal: begin
        reg_write = 1'b1;
        jump      = 1'b1;
      end
      OpJalr: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        jump_r    = 1'b1;
      end
      OpLui: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OpAuipc: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        auipc     = 1'b1;
      end
      OpSystem: begin
        // funct3 == 0 is ECALL/EBREAK: no controls asserted.
        if (funct3 != 3'b000) begin
          is_csr       = 1'b1;
          reg_write    = 1'b1;
          csr_read_en  = 1'b1;
          csr_write_en = (funct3[1:0] != 2'b00);
        end
      end
      default: ;
    endcase
  end

  // ALU-op decoder; jumps always add so the result is the link address.
  always_comb begin
    alu_ctrl = AluAdd;
    if (!(jump || jump_r)) begin
      case (alu_op)
        2'b01: begin
          case (funct3)
            3'b001:  alu_ctrl = AluNe;
            3'b100:  alu_ctrl = AluLt;
            3'b101:  alu_ctrl = AluGe;
            3'b110:  alu_ctrl = AluLtu;
            3'b111:  alu_ctrl = AluGeu;
            default: alu_ctrl = AluEq;
          endcase
        end
        2'b10, 2'b11: begin
          case (funct3)
            3'b000:  alu_ctrl = (alu_op == 2'b10 && funct7[5]) ? AluSub : AluAdd;
            3'b001:  alu_ctrl = AluSll;
            3'b010:  alu_ctrl = AluSlt;
            3'b011:  alu_ctrl = AluSltu;
            3'b100:  alu_ctrl = AluXor;
            3'b101:  alu_ctrl = funct7[5] ? AluSra : AluSrl;
            3'b110:  alu_ctrl = AluOr;
            default: alu_ctrl = AluAnd;
          endcase
        end
        default: alu_ctrl = AluAdd;
      endcase
    end
  end

  // Operand selection.
  always_comb begin
    if (opcode == OpLui) begin
      op_a = 32'd0;
    end else if (auipc || jump || jump_r) begin
      op_a = pc;
    end else begin
      op_a = rs1_val;
    end
    if (jump || jump_r) begin
      op_b = 32'd4;
    end else if (alu_src) begin
      op_b = imm;
    end else begin
      op_b = rs2_val;
    end
  end

  // ALU datapath and flag; compare codes yield 0/1.
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl)
      AluAnd:  alu_result = op_a & op_b;
      AluOr:   alu_result = op_a | op_b;
      AluAdd:  alu_result = op_a + op_b;
      AluXor:  alu_result = op_a ^ op_b;
      AluSll:  alu_result = op_a << op_b[4:0];
      AluSrl:  alu_result = op_a >> op_b[4:0];
      AluSub:  alu_result = op_a - op_b;
      AluSlt:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      AluSra:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      AluSltu: alu_result = {31'd0, op_a < op_b};
      AluEq:   alu_result = {31'd0, op_a == op_b};
      AluNe:   alu_result = {31'd0, op_a != op_b};
      AluLt:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      AluGe:   alu_result = {31'd0, $signed(op_a) >= $signed(op_b)};
      AluLtu:  alu_result = {31'd0, op_a < op_b};
      default: alu_result = {31'd0, op_a >= op_b};
    endcase
    // Branch codes report "condition true" so branch & zero means taken.
    if (alu_ctrl >= AluEq) begin
      zero = alu_result[0];
    end else begin
      zero = (alu_result == 32'd0);
    end
  end

  // Capture register: loads on enabled edges, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
    end else if (en) begin
      result_q <= alu_result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Self-checking bench for exec_ctrl_unit: hand-computed expectations are queued
// as each instruction is driven and compared once the outputs settle.
module tb_exec_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] pc = '0, rs1_val = '0, rs2_val = '0, imm = '0;
  logic        reg_write, alu_src, mem_read, mem_write, branch, jump, jump_r;
  logic        memtoreg, auipc, csr_read_en, csr_write_en, is_csr, zero, zero_q;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result, result_q;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // {reg_write, alu_src, mem_read, mem_write, branch, jump, jump_r, memtoreg,
  //  auipc, alu_op[1:0], csr_read_en, csr_write_en, is_csr}
  localparam logic [13:0] CR     = 14'b1_0_0_0_0_0_0_0_0_10_0_0_0;
  localparam logic [13:0] CI     = 14'b1_1_0_0_0_0_0_0_0_11_0_0_0;
  localparam logic [13:0] CLd    = 14'b1_1_1_0_0_0_0_1_0_00_0_0_0;
  localparam logic [13:0] CSt    = 14'b0_1_0_1_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] CBr    = 14'b0_0_0_0_1_0_0_0_0_01_0_0_0;
  localparam logic [13:0] CJal   = 14'b1_0_0_0_0_1_0_0_0_00_0_0_0;
  localparam logic [13:0] CJalr  = 14'b1_1_0_0_0_0_1_0_0_00_0_0_0;
  localparam logic [13:0] CLui   = 14'b1_1_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] CAuipc = 14'b1_1_0_0_0_0_0_0_1_00_0_0_0;
  localparam logic [13:0] CCsrw  = 14'b1_0_0_0_0_0_0_0_0_00_1_1_1;
  localparam logic [13:0] CNone  = 14'b0;

  typedef struct {
    string       tag;
    logic [13:0] ctrl;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  exec_ctrl_unit dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .pc           (pc),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .imm          (imm),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .branch       (branch),
    .jump         (jump),
    .jump_r       (jump_r),
    .memtoreg     (memtoreg),
    .auipc        (auipc),
    .alu_op       (alu_op),
    .csr_read_en  (csr_read_en),
    .csr_write_en (csr_write_en),
    .is_csr       (is_csr),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .zero         (zero),
    .result_q     (result_q),
    .zero_q       (zero_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction, queue its expectation, then compare after settling.
  task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [13:0] ctl,
                       input logic [3:0] ac, input logic [31:0] res, input logic z);
    exp_t e;
    exp_t got_e;
    e.tag = tag; e.ctrl = ctl; e.alu_ctrl = ac; e.result = res; e.zero = z;
    sb.push_back(e);
    opcode = op; funct3 = f3; funct7 = f7; pc = p; rs1_val = a; rs2_val = b; imm = im;
    #1;
    got_e = sb.pop_front();
    check_eq({got_e.tag, ".ctrl"}, {18'd0, reg_write, alu_src, mem_read, mem_write, branch,
             jump, jump_r, memtoreg, auipc, alu_op, csr_read_en, csr_write_en, is_csr},
             {18'd0, got_e.ctrl});
    check_eq({got_e.tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, got_e.alu_ctrl});
    check_eq({got_e.tag, ".result"}, alu_result, got_e.result);
    check_eq({got_e.tag, ".zero"}, {31'd0, zero}, {31'd0, got_e.zero});
  endtask

  initial begin
    #12;
    check_eq("reset.result_q", result_q, 32'd0);
    check_eq("reset.zero_q", {31'd0, zero_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //     tag       opcode      f3      f7          pc      rs1           rs2           imm
    apply("add",    7'b0110011, 3'b000, 7'b0000000, 32'h0,   32'd5,        32'd7,        32'h0,
          CR, 4'b0010, 32'd12, 1'b0);
    apply("sub",    7'b0110011, 3'b000, 7'b0100000, 32'h0,   32'h1234,     32'h1234,     32'h0,
          CR, 4'b0110, 32'd0, 1'b1);
    apply("addwrap", 7'b0110011, 3'b000, 7'b0000000, 32'h0,  32'hFFFF_FFFF, 32'd1,       32'h0,
          CR, 4'b0010, 32'd0, 1'b1);
    apply("srai",   7'b0010011, 3'b101, 7'b0100000, 32'h0,   32'h8000_0000, 32'h0,       32'h404,
          CI, 4'b1000, 32'hF800_0000, 1'b0);
    apply("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 32'h0,  32'd10,       32'h0,        32'd3,
          CI, 4'b0010, 32'd13, 1'b0);
    apply("sll",    7'b0110011, 3'b001, 7'b0000000, 32'h0,   32'd1,        32'h21,       32'h0,
          CR, 4'b0100, 32'd2, 1'b0);
    apply("slt",    7'b0110011, 3'b010, 7'b0000000, 32'h0,   32'hFFFF_FFFF, 32'd1,       32'h0,
          CR, 4'b0111, 32'd1, 1'b0);
    apply("sltiu",  7'b0010011, 3'b011, 7'b0000000, 32'h0,   32'd5,        32'h0,    32'hFFFF_FFFF,
          CI, 4'b1001, 32'd1, 1'b0);
    apply("xor",    7'b0110011, 3'b100, 7'b0000000, 32'h0,   32'hA5A5,     32'hA5A5,     32'h0,
          CR, 4'b0011, 32'd0, 1'b1);
    apply("bne",    7'b1100011, 3'b001, 7'b0000000, 32'h0,   32'd3,        32'd3,        32'h0,
          CBr, 4'b1011, 32'd0, 1'b0);
    apply("bltu",   7'b1100011, 3'b110, 7'b0000000, 32'h0,   32'd1,    32'hFFFF_FFFF,    32'h0,
          CBr, 4'b1110, 32'd1, 1'b1);
    apply("bge",    7'b1100011, 3'b101, 7'b0000000, 32'h0,   32'hFFFF_FFFF, 32'd0,       32'h0,
          CBr, 4'b1101, 32'd0, 1'b0);
    apply("br_f3_2", 7'b1100011, 3'b010, 7'b0000000, 32'h0,  32'd9,        32'd9,        32'h0,
          CBr, 4'b1010, 32'd1, 1'b1);
    apply("jal",    7'b1101111, 3'b000, 7'b0000000, 32'h100, 32'h55,       32'h66,       32'h40,
          CJal, 4'b0010, 32'h104, 1'b0);
    apply("jalr",   7'b1100111, 3'b000, 7'b0000000, 32'h200, 32'h1000,     32'h0,        32'h8,
          CJalr, 4'b0010, 32'h204, 1'b0);
    apply("auipc",  7'b0010111, 3'b000, 7'b0000000, 32'h100, 32'h77,       32'h0,        32'h2000,
          CAuipc, 4'b0010, 32'h2100, 1'b0);
    apply("lui",    7'b0110111, 3'b000, 7'b0000000, 32'h100, 32'h77,       32'h0,   32'hABCD_E000,
          CLui, 4'b0010, 32'hABCD_E000, 1'b0);
    apply("load",   7'b0000011, 3'b010, 7'b0000000, 32'h0,   32'h1000,     32'h0,        32'd8,
          CLd, 4'b0010, 32'h1008, 1'b0);
    apply("store",  7'b0100011, 3'b010, 7'b0000000, 32'h0,   32'h10,       32'h99,   32'hFFFF_FFFC,
          CSt, 4'b0010, 32'hC, 1'b0);
    apply("csrrs",  7'b1110011, 3'b010, 7'b0000000, 32'h0,   32'd0,        32'd0,        32'h0,
          CCsrw, 4'b0010, 32'd0, 1'b1);
    apply("ecall",  7'b1110011, 3'b000, 7'b0000000, 32'h0,   32'd0,        32'd0,        32'h0,
          CNone, 4'b0010, 32'd0, 1'b1);
    apply("illegal", 7'b0000000, 3'b111, 7'b0100000, 32'h0,  32'd3,        32'd4,        32'h0,
          CNone, 4'b0010, 32'd7, 1'b0);

    // en stayed low through all of the above, so the register still holds reset value.
    check_eq("hold_en0.result_q", result_q, 32'd0);

    // Capture 0x2A.
    @(negedge clk);
    apply("cap_add", 7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h20, 32'h0A, 32'h0,
          CR, 4'b0010, 32'h2A, 1'b0);
    en = 1'b1;
    @(posedge clk); #1;
    check_eq("cap.result_q", result_q, 32'h2A);
    check_eq("cap.zero_q", {31'd0, zero_q}, 32'd0);

    // en low: new combinational result must not be captured.
    @(negedge clk);
    en = 1'b0;
    apply("hold_sub", 7'b0110011, 3'b000, 7'b0100000, 32'h0, 32'h9, 32'h9, 32'h0,
          CR, 4'b0110, 32'd0, 1'b1);
    @(posedge clk); #1;
    check_eq("hold.result_q", result_q, 32'h2A);
    check_eq("hold.zero_q", {31'd0, zero_q}, 32'd0);

    // en high again captures the zero result and flag.
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check_eq("cap0.result_q", result_q, 32'd0);
    check_eq("cap0.zero_q", {31'd0, zero_q}, 32'd1);

    @(negedge clk);
    apply("cap_add2", 7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h20, 32'h0A, 32'h0,
          CR, 4'b0010, 32'h2A, 1'b0);
    @(posedge clk); #1;
    check_eq("cap2.result_q", result_q, 32'h2A);

    // Mid-cycle asynchronous reset clears immediately, well before the next edge.
    #2 rst = 1'b1;
    #1;
    check_eq("arst.result_q", result_q, 32'd0);
    check_eq("arst.alu_result", alu_result, 32'h2A);

    // Reset beats en on a clock edge.
    @(posedge clk); #1;
    check_eq("rst_en.result_q", result_q, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst.result_q", result_q, 32'h2A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
